mapa_tiles: RTL
===============

Name: mapa_tiles

Overview:
- Tile-map storage and responder for the snake game.
- Holds one 2-bit code per map cell: 00 empty, 01 snake, 10 fruit, 11 obstacle.
- Services the game-logic read port (renable/rx/ry -> rdata) and write port (wenable/wx/wy/wdata) driven by the update FSM.
- Provides an independent read port for the VGA renderer.
- Self-clears the map after reset and keeps live occupancy counts.

Parameters:
- MAPA_WIDTH, 40, map columns.
- MAPA_HEIGHT, 30, map rows.
- ADDR_W, 11, cell address width; must satisfy 2^ADDR_W >= MAPA_WIDTH*MAPA_HEIGHT.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low.
- update_renable  input  1  logic read request.
- update_rx  input  10  read column.
- update_ry  input  10  read row.
- update_rdata  output  2  read data.
- update_rvalid  output  1  update_rdata valid pulse.
- update_wenable  input  1  logic write request.
- update_wx  input  10  write column.
- update_wy  input  10  write row.
- update_wdata  input  2  write data.
- vga_x  input  10  render column.
- vga_y  input  10  render row.
- vga_rdata  output  2  render cell code.
- busy  output  1  map clear in progress; requests ignored.
- cobra_cells  output  11  number of cells holding 01.
- fruta_cells  output  11  number of cells holding 10.

Behaviour:
- Interface rule: reset reset, synchronous, active-low; clock clk.
- Cell address = y*MAPA_WIDTH + x, computed in ADDR_W bits.

Reset:
- While reset==0 at a clk edge, all outputs clear: update_rdata=0, update_rvalid=0, vga_rdata=0, cobra_cells=0, fruta_cells=0, busy=1.
- Clear pointer = 0, pending write discarded, state = CLEAR.
- reset asserted mid-CLEAR or mid-write restarts CLEAR from cell 0.

State CLEAR:
- Writes 00 to one cell per cycle, pointer 0..W*H-1.
- busy=1; read and write requests are ignored and update_rvalid stays 0.
- vga_rdata returns 00.
- After writing cell W*H-1 (1200 cycles with defaults), the next edge enters READY with busy=0.

State READY, write port:
- Request sampled at edge N, cell committed at edge N+1.
- Out-of-range coordinates (x>=MAPA_WIDTH or y>=MAPA_HEIGHT) are dropped silently.
- Back-to-back writes accepted every cycle.

State READY, logic read:
- update_renable sampled at edge N; update_rdata and update_rvalid=1 registered at edge N, held for one cycle, then rvalid=0.
- update_rdata holds its last value until the next read.
- Out-of-range read returns 11, so wrap-free walls read as obstacles.

Read/write ordering:
- Read of a cell whose write was sampled at edge N-1 (commit pending) returns the new value via forwarding.
- Read and write to the same cell sampled at the same edge: read returns the old value.

VGA port:
- vga_rdata registered every cycle from vga_x/vga_y; latency 1.
- Out-of-range returns 00.
- No forwarding: commit-cycle skew is acceptable for display.

Occupancy counters:
- On each commit, decrement the counter matching the old code and increment the counter matching the new code.
- Writing the same code leaves counts unchanged.
- Counts are exact at the edge after commit.
- Back-to-back writes to the same cell must use the forwarded old value, never the stale array value.
- Counters saturate at 0 and at W*H; no wrap.
- CLEAR leaves both counters at 0.

Optional Feature:
- Macro: MAPA_TILES_STATS_EN.
- Defined: cobra_cells and fruta_cells are maintained as above.
- Undefined: both outputs are tied to 0, no old-value tracking logic is built, and write/read timing is otherwise identical.

Test Plan:
- Reset low 3 cycles, then high -> busy=1 for exactly 1200 cycles, then 0; reading (5,5) afterwards returns 00 with rvalid one cycle after request; counters 0.
- Write (10,10)=01, next cycle read (10,10) -> rdata=01; cobra_cells=1; vga_x=10,vga_y=10 gives vga_rdata=01 within 2 cycles.
- Write (13,13)=10, then (13,13)=01 on consecutive cycles -> cell reads 01; fruta_cells=0, cobra_cells=1.
- Same-edge write (3,4)=10 and read (3,4) -> rdata=00; read on the following cycle -> 10.
- Read (40,0) and (0,30) -> rdata=11; write (40,0)=01 -> no cell changes, counters unchanged.
- reset pulled low at CLEAR pointer 600, released -> busy lasts another full 1200 cycles; requests during busy produce no rvalid and no writes. Repeat the scenarios with MAPA_TILES_STATS_EN undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/mapa_tiles.sv
// ---------------------------------------------------------------------------
// mapa_tiles -- tile-map storage and responder for the snake game.
//
// Holds one 2-bit code per map cell (00 empty, 01 snake, 10 fruit,
// 11 obstacle). After reset the map is cleared one cell per cycle while
// busy is high. Once clear, the game logic reads and writes cells through
// the update_* ports, and the VGA renderer reads cells through vga_*.
//
// Optional feature macro: MAPA_TILES_STATS_EN
//   defined   -> cobra_cells / fruta_cells track live snake / fruit counts
//   undefined -> both counters are tied to 0 and no old-value tracking exists
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   update_renable  logic read request, sampled on clk
//   update_rx/ry    logic read column / row
//   update_rdata    registered read data (11 for out-of-range cells)
//   update_rvalid   one-cycle pulse marking a fresh update_rdata
//   update_wenable  logic write request, committed one edge after sampling
//   update_wx/wy    logic write column / row
//   update_wdata    logic write code
//   vga_x/vga_y     render column / row
//   vga_rdata       registered render cell code (00 for out-of-range)
//   busy            map clear in progress, requests are ignored
//   cobra_cells     number of cells holding 01
//   fruta_cells     number of cells holding 10
// ---------------------------------------------------------------------------
module mapa_tiles #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int ADDR_W      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_renable,
    input  logic [9:0]  update_rx,
    input  logic [9:0]  update_ry,
    output logic [1:0]  update_rdata,
    output logic        update_rvalid,
    input  logic        update_wenable,
    input  logic [9:0]  update_wx,
    input  logic [9:0]  update_wy,
    input  logic [1:0]  update_wdata,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    output logic [1:0]  vga_rdata,
    output logic        busy,
    output logic [10:0] cobra_cells,
    output logic [10:0] fruta_cells
);

    localparam int                CELLS   = MAPA_WIDTH * MAPA_HEIGHT;
    localparam logic [9:0]        W_LIM   = 10'(MAPA_WIDTH);
    localparam logic [9:0]        H_LIM   = 10'(MAPA_HEIGHT);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(MAPA_WIDTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Map storage; contents are defined by the clear sweep, not by reset.
    logic [1:0] mem_q [0:CELLS-1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [1:0]        mem_wdata;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
    logic              busy_q,      busy_d;
    logic [1:0]        rdata_q,     rdata_d;
    logic              rvalid_q,    rvalid_d;
    logic [1:0]        vga_rdata_q, vga_rdata_d;
    logic              wr_pend_q,   wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [1:0]        wr_data_q,   wr_data_d;

    logic              r_in;
    logic              w_in;
    logic              v_in;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] v_addr;
    logic [1:0]        r_fwd;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x,
                                                    input logic [9:0] y);
        return ADDR_W'(y) * WIDTH_A + ADDR_W'(x);
    endfunction

    assign r_in   = (update_rx < W_LIM) && (update_ry < H_LIM);
    assign w_in   = (update_wx < W_LIM) && (update_wy < H_LIM);
    assign v_in   = (vga_x < W_LIM) && (vga_y < H_LIM);
    assign r_addr = cell_addr(update_rx, update_ry);
    assign w_addr = cell_addr(update_wx, update_wy);
    assign v_addr = cell_addr(vga_x, vga_y);

    // A read sampled while a write to the same cell is still waiting to
    // commit must see the pending value, not the array contents.
    assign r_fwd = (wr_pend_q && (wr_addr_q == r_addr)) ? wr_data_q
                                                        : mem_q[r_addr];

`ifdef MAPA_TILES_STATS_EN
    localparam logic [10:0] CNT_MAX = 11'(CELLS);

    logic [1:0]  wr_old_q, wr_old_d;
    logic [10:0] cobra_q,  cobra_d;
    logic [10:0] fruta_q,  fruta_d;
    logic [1:0]  w_old;

    // The code being overwritten is captured when the write is sampled.
    // Forwarding from the pending write keeps back-to-back writes to the
    // same cell from counting against a stale array value.
    assign w_old = (wr_pend_q && (wr_addr_q == w_addr)) ? wr_data_q
                                                        : mem_q[w_addr];

    assign cobra_cells = cobra_q;
    assign fruta_cells = fruta_q;
`else
    assign cobra_cells = '0;
    assign fruta_cells = '0;
`endif

    assign update_rdata  = rdata_q;
    assign update_rvalid = rvalid_q;
    assign vga_rdata     = vga_rdata_q;
    assign busy          = busy_q;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        busy_d      = busy_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        vga_rdata_d = 2'b00;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr_q;
        mem_wdata   = wr_data_q;
`ifdef MAPA_TILES_STATS_EN
        wr_old_d    = wr_old_q;
        cobra_d     = cobra_q;
        fruta_d     = fruta_q;
`endif

        case (state_q)
            ST_CLEAR: begin
                busy_d = 1'b1;
                // The pointer runs one past the last cell so that the final
                // write and the move to READY land on separate edges.
                if (clear_ptr_q == CELLS_A) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end else begin
                    mem_we      = 1'b1;
                    mem_waddr   = clear_ptr_q;
                    mem_wdata   = 2'b00;
                    clear_ptr_d = clear_ptr_q + 1'b1;
                end
            end

            ST_READY: begin
                busy_d = 1'b0;

                mem_we = wr_pend_q;

                if (update_renable) begin
                    rvalid_d = 1'b1;
                    rdata_d  = r_in ? r_fwd : 2'b11;
                end

                if (v_in) begin
                    vga_rdata_d = mem_q[v_addr];
                end

                if (update_wenable && w_in) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = w_addr;
                    wr_data_d = update_wdata;
`ifdef MAPA_TILES_STATS_EN
                    wr_old_d  = w_old;
`endif
                end

`ifdef MAPA_TILES_STATS_EN
                // Old and new codes differ here, so a counter is never both
                // decremented and incremented in the same commit.
                if (wr_pend_q && (wr_old_q != wr_data_q)) begin
                    case (wr_old_q)
                        2'b01: if (cobra_q != '0) cobra_d = cobra_q - 1'b1;
                        2'b10: if (fruta_q != '0) fruta_d = fruta_q - 1'b1;
                        default: ;
                    endcase
                    case (wr_data_q)
                        2'b01: if (cobra_q != CNT_MAX) cobra_d = cobra_q + 1'b1;
                        2'b10: if (fruta_q != CNT_MAX) fruta_d = fruta_q + 1'b1;
                        default: ;
                    endcase
                end
`endif
            end

            default: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            busy_q      <= 1'b1;
            rdata_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            vga_rdata_q <= 2'b00;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 2'b00;
`ifdef MAPA_TILES_STATS_EN
            wr_old_q    <= 2'b00;
            cobra_q     <= '0;
            fruta_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            vga_rdata_q <= vga_rdata_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef MAPA_TILES_STATS_EN
            wr_old_q    <= wr_old_d;
            cobra_q     <= cobra_d;
            fruta_q     <= fruta_d;
`endif
        end
    end

    // Reset discards any pending commit and stops the clear sweep.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
